// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions for the LSU slice: funct3 codes,
// the LSU state encoding, and helpers that classify and encode an access.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_enc_t;

  // An access is rejected when its width does not fit the byte offset or when
  // the funct3 code names no load/store width (stores only know B/H/W).
  function automatic logic lsu_misaligned(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = off[0];
        F3_SW:   bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = off[0];
        F3_LW:         bad = (off != 2'b00);
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // Stores replicate the datum across every lane so the memory only needs the
  // strobes to pick the right bytes; loads never drive strobes.
  function automatic store_enc_t lsu_store_encode(input logic        is_store,
                                                  input logic [2:0]  funct3,
                                                  input logic [1:0]  off,
                                                  input logic [31:0] data);
    store_enc_t enc;
    enc.wstrb = 4'b0000;
    enc.wdata = 32'd0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          enc.wdata = {4{data[7:0]}};
          enc.wstrb = 4'b0001 << off;
        end
        F3_SH: begin
          enc.wdata = {2{data[15:0]}};
          enc.wstrb = 4'b0011 << off;
        end
        F3_SW: begin
          enc.wdata = data;
          enc.wstrb = 4'b1111;
        end
        default: begin
          enc.wdata = 32'd0;
          enc.wstrb = 4'b0000;
        end
      endcase
    end
    return enc;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends
// it to 32 bits according to the load's funct3.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection followed by extension; unknown codes yield zero.
  always_comb begin
    byteSel  = 8'd0;
    halfSel  = 16'd0;
    result_o = 32'd0;
    case (off_i)
      2'd0:    byteSel = rdata_i[7:0];
      2'd1:    byteSel = rdata_i[15:8];
      2'd2:    byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    halfSel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   result_o = {{24{byteSel[7]}}, byteSel};
      F3_LBU:  result_o = {24'd0, byteSel};
      F3_LH:   result_o = {{16{halfSel[15]}}, halfSel};
      F3_LHU:  result_o = {16'd0, halfSel};
      F3_LW:   result_o = rdata_i;
      default: result_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_data_access.sv
// Load/store unit sitting between execute and writeback. Accepts one access
// per instruction, runs it on a req/ack data bus, stalls the pipeline while
// the bus is busy, and delivers aligned/extended load data to writeback.
module lsu_data_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        execute_valid,
  input  logic        execute_mem_read,
  input  logic        execute_mem_write,
  input  logic [2:0]  execute_funct3,
  input  logic [31:0] execute_alu_result,
  input  logic [31:0] execute_store_data,
  output logic [31:0] mem_read_data,
  output logic        lsu_done,
  output logic        lsu_stall,
  output logic        lsu_misalign,
  output logic        lsu_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q;
  logic            we_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     wdata_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [31:0]     rdata_q;
  logic            done_q;
  logic            misalign_q;
  logic            busErr_q;

  logic        access;
  logic        isStore;
  logic        misaligned;
  logic        accept;
  logic        misHit;
  logic        ackHit;
  logic        timeout;
  store_enc_t  storeEnc;
  logic [31:0] loadData;

  // Classify the execute-stage instruction; a load+store combination is a store.
  always_comb begin
    access     = execute_valid & (execute_mem_read | execute_mem_write);
    isStore    = execute_mem_write;
    misaligned = lsu_misaligned(isStore, execute_funct3, execute_alu_result[1:0]);
    storeEnc   = lsu_store_encode(isStore, execute_funct3,
                                  execute_alu_result[1:0], execute_store_data);
  end

  // Next-state and bus/stall control; the ack cycle drops stall so the
  // pipeline advances on the same edge the access retires.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    misHit    = 1'b0;
    ackHit    = 1'b0;
    timeout   = 1'b0;
    lsu_stall = 1'b0;
    dmem_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && misaligned) begin
          misHit = 1'b1;
        end else if (access) begin
          accept    = 1'b1;
          state_d   = REQ;
          cnt_d     = '0;
          lsu_stall = 1'b1;
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          ackHit  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LastCnt) begin
          timeout   = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          lsu_stall = 1'b1;
        end else begin
          cnt_d     = cnt_q + CntW'(1);
          lsu_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .result_o (loadData)
  );

  // State, latched request fields, load result and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= ackHit;
      misalign_q <= misHit;
      busErr_q   <= timeout;
      if (accept) begin
        addr_q   <= {execute_alu_result[31:2], 2'b00};
        we_q     <= isStore;
        wstrb_q  <= storeEnc.wstrb;
        wdata_q  <= storeEnc.wdata;
        funct3_q <= execute_funct3;
        off_q    <= execute_alu_result[1:0];
      end
      if (ackHit && !we_q) begin
        rdata_q <= loadData;
      end else if (timeout) begin
        rdata_q <= 32'd0;
      end
    end
  end

  assign mem_read_data = rdata_q;
  assign lsu_done      = done_q;
  assign lsu_misalign  = misalign_q;
  assign lsu_bus_err   = busErr_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wstrb    = wstrb_q;
  assign dmem_wdata    = wdata_q;

endmodule

// File: tb/tb_lsu_data_access.sv
// Bench for lsu_data_access: a table of directed accesses, hand-written
// timeout and reset sequences, then random accesses against a reference model.
module tb_lsu_data_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        execute_valid, execute_mem_read, execute_mem_write;
  logic [2:0]  execute_funct3;
  logic [31:0] execute_alu_result, execute_store_data;
  logic [31:0] mem_read_data;
  logic        lsu_done, lsu_stall, lsu_misalign, lsu_bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expMem = 32'd0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic        expMis;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expRead;
  } vec_t;

  lsu_data_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .execute_valid      (execute_valid),
    .execute_mem_read   (execute_mem_read),
    .execute_mem_write  (execute_mem_write),
    .execute_funct3     (execute_funct3),
    .execute_alu_result (execute_alu_result),
    .execute_store_data (execute_store_data),
    .mem_read_data      (mem_read_data),
    .lsu_done           (lsu_done),
    .lsu_stall          (lsu_stall),
    .lsu_misalign       (lsu_misalign),
    .lsu_bus_err        (lsu_bus_err),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wstrb         (dmem_wstrb),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic clearInputs();
    execute_valid      = 1'b0;
    execute_mem_read   = 1'b0;
    execute_mem_write  = 1'b0;
    execute_funct3     = 3'd0;
    execute_alu_result = 32'd0;
    execute_store_data = 32'd0;
  endtask

  function automatic vec_t mkVec(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input int waits, input logic mis,
                                 input logic [3:0] strb, input logic [31:0] wdata,
                                 input logic [31:0] rv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.waits = waits; v.expMis = mis; v.expStrb = strb; v.expWdata = wdata; v.expRead = rv;
    return v;
  endfunction

  // Reference model: access size from funct3, alignment by modulo, store data
  // by multiplication-replication, loads by shift/mask/extend.
  function automatic vec_t modelVec(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] sdata,
                                    input logic [31:0] rdata, input int waits);
    vec_t        v;
    int          size;
    int          off;
    bit          legal;
    bit          uns;
    logic [31:0] mask;
    logic [31:0] val;
    v = mkVec(rd, wr, f3, addr, sdata, rdata, waits, 1'b0, 4'd0, 32'd0, 32'd0);
    if (!rd && !wr) return v;
    off = int'(addr % 32'd4);
    size = 1; legal = 1'b1; uns = 1'b0;
    if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'd0: size = 1;
        3'd4: begin size = 1; uns = 1'b1; end
        3'd1: size = 2;
        3'd5: begin size = 2; uns = 1'b1; end
        3'd2: size = 4;
        default: legal = 1'b0;
      endcase
    end
    if (!legal || (off % size) != 0) begin
      v.expMis = 1'b1;
      return v;
    end
    if (wr) begin
      v.expStrb = 4'(((1 << size) - 1) << off);
      if (size == 1) v.expWdata = 32'(sdata[7:0]) * 32'h01010101;
      else if (size == 2) v.expWdata = 32'(sdata[15:0]) * 32'h00010001;
      else v.expWdata = sdata;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val = (rdata >> (8 * off)) & mask;
      if (!uns && size < 4 && val[8 * size - 1]) val = val | ~mask;
      v.expRead = val;
    end
    return v;
  endfunction

  // Drives one access starting in the current cycle and ends in the cycle
  // right after it retires, so the next call runs back-to-back.
  task automatic applyStimulus(input vec_t v);
    logic access;
    logic isLoad;
    access = v.rd | v.wr;
    isLoad = v.rd & ~v.wr;
    execute_valid      = 1'b1;
    execute_mem_read   = v.rd;
    execute_mem_write  = v.wr;
    execute_funct3     = v.f3;
    execute_alu_result = v.addr;
    execute_store_data = v.sdata;
    #1;
    checkOutput("stallAccess", 32'(lsu_stall), 32'(access & ~v.expMis));
    checkOutput("reqAccess", 32'(dmem_req), 32'd0);
    tick();
    clearInputs();
    if (!access || v.expMis) begin
      #1;
      checkOutput("misalignPulse", 32'(lsu_misalign), 32'(access & v.expMis));
      checkOutput("reqNone", 32'(dmem_req), 32'd0);
      checkOutput("stallNone", 32'(lsu_stall), 32'd0);
      checkOutput("doneNone", 32'(lsu_done), 32'd0);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        if (w == v.waits) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
        end else begin
          dmem_rdata = $urandom();
        end
        #1;
        checkOutput("reqHeld", 32'(dmem_req), 32'd1);
        checkOutput("addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
        checkOutput("we", 32'(dmem_we), 32'(v.wr));
        checkOutput("wstrb", 32'(dmem_wstrb), 32'(v.expStrb));
        if (!isLoad) checkOutput("wdata", dmem_wdata, v.expWdata);
        checkOutput("stallReq", 32'(lsu_stall), 32'(w != v.waits));
        checkOutput("doneEarly", 32'(lsu_done), 32'd0);
        tick();
        dmem_ack = 1'b0;
      end
      checkOutput("donePulse", 32'(lsu_done), 32'd1);
      checkOutput("reqDropped", 32'(dmem_req), 32'd0);
      checkOutput("noMisalign", 32'(lsu_misalign), 32'd0);
      checkOutput("noBusErr", 32'(lsu_bus_err), 32'd0);
      if (isLoad) expMem = v.expRead;
    end
    checkOutput("readData", mem_read_data, expMem);
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    tbl[0]  = mkVec(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mkVec(0, 1, 3'b000, 32'h103, 32'h0000005A, 32'h0, 0, 0, 4'h8, 32'h5A5A5A5A, 32'h0);
    tbl[2]  = mkVec(1, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 0, 0, 4'h0, 32'h0, 32'hFFFFFF80);
    tbl[3]  = mkVec(1, 0, 3'b100, 32'h103, 32'h0, 32'h80000000, 1, 0, 4'h0, 32'h0, 32'h00000080);
    tbl[4]  = mkVec(1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 0, 4'h0, 32'h0, 32'hFFFF8001);
    tbl[5]  = mkVec(1, 0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 0, 4'h0, 32'h0, 32'h00008001);
    tbl[6]  = mkVec(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    tbl[7]  = mkVec(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    tbl[8]  = mkVec(0, 1, 3'b010, 32'h200, 32'h12345678, 32'h0, 5, 0, 4'hF, 32'h12345678, 32'h0);
    tbl[9]  = mkVec(0, 1, 3'b001, 32'h206, 32'h0000ABCD, 32'h0, 2, 0, 4'hC, 32'hABCDABCD, 32'h0);
    tbl[10] = mkVec(0, 1, 3'b100, 32'h200, 32'h11223344, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    tbl[11] = mkVec(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h11111111, 0, 0, 4'hF, 32'hCAFEF00D, 32'h0);
    tbl[12] = mkVec(1, 0, 3'b010, 32'h040, 32'h0, 32'h13572468, 2, 0, 4'h0, 32'h0, 32'h13572468);
    tbl[13] = mkVec(0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    tbl[14] = mkVec(0, 0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    tbl[15] = mkVec(1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0, 4'h0, 32'h0, 32'h0000007F);

    clearInputs();
    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    tick();
    tick();
    checkOutput("rstReadData", mem_read_data, 32'd0);
    checkOutput("rstReq", 32'(dmem_req), 32'd0);
    checkOutput("rstPulses", 32'({lsu_done, lsu_misalign, lsu_bus_err, lsu_stall}), 32'd0);
    checkOutput("rstBus", dmem_addr | dmem_wdata | 32'(dmem_wstrb) | 32'(dmem_we), 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] directed table");
    for (int i = 0; i < 16; i++) applyStimulus(tbl[i]);

    $display("[TB] ack timeout");
    execute_valid = 1'b1; execute_mem_read = 1'b1; execute_funct3 = 3'b010;
    execute_alu_result = 32'h500;
    tick();
    clearInputs();
    for (int c = 0; c < 16; c++) begin
      #1;
      checkOutput("toReq", 32'(dmem_req), 32'd1);
      checkOutput("toStall", 32'(lsu_stall), 32'd1);
      checkOutput("toNoErr", 32'(lsu_bus_err), 32'd0);
      tick();
    end
    checkOutput("toErrPulse", 32'(lsu_bus_err), 32'd1);
    checkOutput("toReqDrop", 32'(dmem_req), 32'd0);
    checkOutput("toReadZero", mem_read_data, 32'd0);
    checkOutput("toNoDone", 32'(lsu_done), 32'd0);
    expMem = 32'd0;
    tick();
    checkOutput("toErrEnd", 32'(lsu_bus_err), 32'd0);

    $display("[TB] reset mid request");
    applyStimulus(mkVec(1, 0, 3'b010, 32'h044, 32'h0, 32'h89ABCDEF, 0, 0, 4'h0, 32'h0, 32'h89ABCDEF));
    execute_valid = 1'b1; execute_mem_write = 1'b1; execute_funct3 = 3'b010;
    execute_alu_result = 32'h600; execute_store_data = 32'h55AA55AA;
    tick();
    clearInputs();
    #1;
    checkOutput("rmReq", 32'(dmem_req), 32'd1);
    rst      = 1'b0;
    dmem_ack = 1'b1;
    tick();
    checkOutput("rmReqLow", 32'(dmem_req), 32'd0);
    checkOutput("rmNoDone", 32'(lsu_done), 32'd0);
    checkOutput("rmNoErr", 32'(lsu_bus_err), 32'd0);
    checkOutput("rmReadZero", mem_read_data, 32'd0);
    rst      = 1'b1;
    dmem_ack = 1'b0;
    expMem   = 32'd0;
    tick();
    checkOutput("rmStillNoDone", 32'(lsu_done | lsu_bus_err | dmem_req), 32'd0);

    $display("[TB] random accesses");
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic        rd, wr;
      logic [31:0] addr;
      kind = int'($urandom_range(0, 7));
      rd = (kind >= 1 && kind <= 3) || kind == 7;
      wr = kind >= 4;
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rv = modelVec(rd, wr, 3'($urandom_range(0, 7)), addr, $urandom(), $urandom(),
                    int'($urandom_range(0, 3)));
      applyStimulus(rv);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
